// File: rtl/disp_pkg.sv
// disp_pkg: shared segment width, segment type and digit patterns for the 7-segment decoder.
package disp_pkg;
    localparam int SEG_W = 7;
    typedef logic [SEG_W-1:0] seg_t;
    localparam seg_t SEG_0   = 7'b1111110;
    localparam seg_t SEG_1   = 7'b0110000;
    localparam seg_t SEG_2   = 7'b1101101;
    localparam seg_t SEG_3   = 7'b1111001;
    localparam seg_t SEG_4   = 7'b0110011;
    localparam seg_t SEG_5   = 7'b1011011;
    localparam seg_t SEG_6   = 7'b1011111;
    localparam seg_t SEG_7   = 7'b1110000;
    localparam seg_t SEG_OFF = 7'b0000000;
endpackage

// File: rtl/disp_7s_lut.sv
// disp_7s_lut: combinational 3-bit code to lit-high segment pattern {a,b,c,d,e,f,g}.
//   code : 3-bit octal digit, MSB first
//   seg  : segment pattern, bit 6 = a, 1 = lit
module disp_7s_lut
    import disp_pkg::*;
(
    input  logic [2:0] code,
    output seg_t       seg
);
    always_comb begin
        seg = SEG_OFF;
        case (code)
            3'd0:    seg = SEG_0;
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = SEG_4;
            3'd5:    seg = SEG_5;
            3'd6:    seg = SEG_6;
            3'd7:    seg = SEG_7;
            default: seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/disp_7s.sv
// disp_7s: registered octal-digit 7-segment driver with optional common-anode inversion.
//   clk, rst     : clock, synchronous active-high reset (all segments off)
//   A, B, C      : digit code, A = MSB
//   Fa .. Fg     : registered segment drives, one cycle after the code is sampled
module disp_7s
    import disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    output logic Fa,
    output logic Fb,
    output logic Fc,
    output logic Fd,
    output logic Fe,
    output logic Ff,
    output logic Fg
);
    localparam seg_t OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    seg_t lut_seg;
    seg_t seg_d;
    seg_t seg_q;
    disp_7s_lut u_lut (
        .code ({A, B, C}),
        .seg  (lut_seg)
    );
    always_comb begin
        seg_d = ACTIVE_LOW ? ~lut_seg : lut_seg;
    end
    always_ff @(posedge clk) begin
        if (rst) seg_q <= OFF;
        else     seg_q <= seg_d;
    end
    assign {Fa, Fb, Fc, Fd, Fe, Ff, Fg} = seg_q;
endmodule

// File: tb/tb_disp_7s.sv
// tb_disp_7s: directed self-checking bench for disp_7s in both polarities.
module tb_disp_7s;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0;
    logic ha, hb, hc, hd, he, hf, hg;
    logic la, lb, lc, ld, le, lf, lg;
    logic [6:0] seg_h, seg_l;
    int n_checks = 0;
    int n_fail = 0;
    logic [6:0] exp_tab [8];

    always #5 clk = ~clk;

    disp_7s #(.ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .A(a), .B(b), .C(c),
        .Fa(ha), .Fb(hb), .Fc(hc), .Fd(hd), .Fe(he), .Ff(hf), .Fg(hg)
    );
    disp_7s #(.ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .A(a), .B(b), .C(c),
        .Fa(la), .Fb(lb), .Fc(lc), .Fd(ld), .Fe(le), .Ff(lf), .Fg(lg)
    );

    assign seg_h = {ha, hb, hc, hd, he, hf, hg};
    assign seg_l = {la, lb, lc, ld, le, lf, lg};

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input logic [2:0] v);
        {a, b, c} = v;
    endtask

    initial begin
        exp_tab[0] = 7'b1111110;
        exp_tab[1] = 7'b0110000;
        exp_tab[2] = 7'b1101101;
        exp_tab[3] = 7'b1111001;
        exp_tab[4] = 7'b0110011;
        exp_tab[5] = 7'b1011011;
        exp_tab[6] = 7'b1011111;
        exp_tab[7] = 7'b1110000;

        rst = 1'b1;
        set_code(3'b101);
        tick();
        tick();
        check("rst_h", seg_h, 7'b0000000);
        check("rst_l", seg_l, 7'b1111111);
        rst = 1'b0;
        tick();
        check("post_rst_h", seg_h, 7'b1011011);
        check("post_rst_l", seg_l, 7'b0100100);

        for (int i = 0; i < 8; i++) begin
            set_code(3'(i));
            tick();
            check($sformatf("sweep_h_%0d", i), seg_h, exp_tab[i]);
            check($sformatf("sweep_l_%0d", i), seg_l, ~exp_tab[i]);
        end

        set_code(3'b000);
        #3;
        check("wrap_hold", seg_h, 7'b1110000);
        tick();
        check("wrap_h", seg_h, 7'b1111110);
        check("wrap_l", seg_l, 7'b0000001);

        set_code(3'b011);
        tick();
        check("pre_mid_rst", seg_h, 7'b1111001);
        rst = 1'b1;
        tick();
        check("mid_rst_h", seg_h, 7'b0000000);
        check("mid_rst_l", seg_l, 7'b1111111);
        rst = 1'b0;
        tick();
        check("rel_h", seg_h, 7'b1111001);
        check("rel_l", seg_l, 7'b0000110);

        set_code(3'b010);
        tick();
        check("glitch_base", seg_h, 7'b1101101);
        #1;
        set_code(3'b101);
        #2;
        set_code(3'b010);
        #1;
        check("glitch_h", seg_h, 7'b1101101);
        check("glitch_l", seg_l, 7'b0010010);
        tick();
        check("glitch_after", seg_h, 7'b1101101);

        set_code(3'b110);
        tick();
        check("six_h", seg_h, 7'b1011111);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
